// File: rtl/pipeline_hazard_scheduler.sv
// Central stall/squash sequencer for the 5-stage core (I, D, E, M, W).
// Tracks in-flight destinations, stalls issue on RAW hazards, squashes I on a
// taken jump from D, freezes the pipe on memory stalls, and drains/halts on flush.
module pipeline_hazard_scheduler #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [REG_W-1:0] issue_rs1,
    input  logic [REG_W-1:0] issue_rs2,
    input  logic             issue_uses_rs1,
    input  logic             issue_uses_rs2,
    input  logic [REG_W-1:0] issue_rd,
    input  logic             issue_writes_rd,
    input  logic             jump_taken,
    input  logic             mem_stall,
    input  logic             flush_req,
    input  logic             resume,
    output logic             pc_en,
    output logic             stall_issue,
    output logic             squash_issue,
    output logic             pipe_freeze,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] squash_count
);

    localparam int unsigned SB_DEPTH = 4;
    localparam int unsigned SB_D     = 0;
    localparam int unsigned SB_E     = 1;
    localparam int unsigned SB_M     = 2;
    localparam int unsigned SB_W     = 3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [SB_DEPTH-1:0] sb_vld_q, sb_vld_d;
    logic [REG_W-1:0]   sb_rd_q [SB_DEPTH];
    logic [REG_W-1:0]   sb_rd_d [SB_DEPTH];
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   squash_cnt_q, squash_cnt_d;

    logic in_run_c;
    logic rs1_hit_c;
    logic rs2_hit_c;
    logic hazard_c;
    logic issue_adv_c;

    // A register that can actually carry a dependency: not r0, inside the file.
    function automatic logic is_live_reg(input logic [REG_W-1:0] idx);
        return (idx != '0) && ({1'b0, idx} < (REG_W+1)'(NREGS));
    endfunction

    assign in_run_c = (state_q == ST_RUN);

    // RAW detection against producers in D, E and M (W writes back this edge).
    always_comb begin
        rs1_hit_c = (sb_vld_q[SB_D] && (sb_rd_q[SB_D] == issue_rs1)) ||
                    (sb_vld_q[SB_E] && (sb_rd_q[SB_E] == issue_rs1)) ||
                    (sb_vld_q[SB_M] && (sb_rd_q[SB_M] == issue_rs1));
        rs2_hit_c = (sb_vld_q[SB_D] && (sb_rd_q[SB_D] == issue_rs2)) ||
                    (sb_vld_q[SB_E] && (sb_rd_q[SB_E] == issue_rs2)) ||
                    (sb_vld_q[SB_M] && (sb_rd_q[SB_M] == issue_rs2));
        hazard_c  = issue_valid && in_run_c &&
                    ((issue_uses_rs1 && is_live_reg(issue_rs1) && rs1_hit_c) ||
                     (issue_uses_rs2 && is_live_reg(issue_rs2) && rs2_hit_c));
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: flush drains until the scoreboard is empty, resume restarts.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:    if (flush_req)  state_d = ST_DRAIN;
            ST_DRAIN:  if (~|sb_vld_q) state_d = ST_HALTED;
            ST_HALTED: if (resume)     state_d = ST_RUN;
            default:                   state_d = ST_RUN;
        endcase
    end

    // FSM outputs: mem_stall > jump squash > hazard / drain / halt > run.
    always_comb begin
        pc_en        = 1'b0;
        stall_issue  = 1'b0;
        squash_issue = 1'b0;
        pipe_freeze  = 1'b0;
        halted       = (state_q == ST_HALTED);
        if (mem_stall) begin
            pipe_freeze = 1'b1;
            stall_issue = 1'b1;
        end else if (jump_taken) begin
            squash_issue = 1'b1;
            pc_en        = 1'b1;
        end else if (hazard_c || !in_run_c || flush_req) begin
            stall_issue = 1'b1;
        end else begin
            pc_en = 1'b1;
        end
        issue_adv_c = in_run_c && !stall_issue && !squash_issue;
    end

    // Scoreboard shift; I enters D only when it truly advances, else a bubble.
    always_comb begin
        sb_vld_d = sb_vld_q;
        sb_rd_d  = sb_rd_q;
        if (!pipe_freeze) begin
            sb_vld_d[SB_W] = sb_vld_q[SB_M];
            sb_rd_d[SB_W]  = sb_rd_q[SB_M];
            sb_vld_d[SB_M] = sb_vld_q[SB_E];
            sb_rd_d[SB_M]  = sb_rd_q[SB_E];
            sb_vld_d[SB_E] = sb_vld_q[SB_D];
            sb_rd_d[SB_E]  = sb_rd_q[SB_D];
            sb_vld_d[SB_D] = issue_adv_c && issue_valid && issue_writes_rd &&
                             is_live_reg(issue_rd);
            sb_rd_d[SB_D]  = issue_rd;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_vld_q <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_rd_q[i] <= '0;
            end
        end else begin
            sb_vld_q <= sb_vld_d;
            sb_rd_q  <= sb_rd_d;
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        squash_cnt_d = squash_cnt_q;
        if (hazard_c && !mem_stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (squash_issue && !(&squash_cnt_q)) begin
            squash_cnt_d = squash_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign squash_count = squash_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_scheduler.sv
// Bench for pipeline_hazard_scheduler: directed vector table, hand-written
// drain/reset/saturation sequences, and random traffic against a queue model.
module tb_pipeline_hazard_scheduler;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned SAT_W = 4;

    logic clk = 1'b0;
    logic rst;
    logic issue_valid, issue_uses_rs1, issue_uses_rs2, issue_writes_rd;
    logic [REG_W-1:0] issue_rs1, issue_rs2, issue_rd;
    logic jump_taken, mem_stall, flush_req, resume;

    logic pc_en, stall_issue, squash_issue, pipe_freeze, halted;
    logic [CNT_W-1:0] stall_cycles, squash_count;
    logic s_pc_en, s_stall_issue, s_squash_issue, s_pipe_freeze, s_halted;
    logic [SAT_W-1:0] s_stall_cycles, s_squash_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_scheduler u_dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_uses_rs1(issue_uses_rs1), .issue_uses_rs2(issue_uses_rs2),
        .issue_rd(issue_rd), .issue_writes_rd(issue_writes_rd),
        .jump_taken(jump_taken), .mem_stall(mem_stall),
        .flush_req(flush_req), .resume(resume),
        .pc_en(pc_en), .stall_issue(stall_issue), .squash_issue(squash_issue),
        .pipe_freeze(pipe_freeze), .halted(halted),
        .stall_cycles(stall_cycles), .squash_count(squash_count)
    );

    // Narrow-counter copy so saturation is reachable in a few cycles.
    pipeline_hazard_scheduler #(.CNT_W(SAT_W)) u_sat (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_uses_rs1(issue_uses_rs1), .issue_uses_rs2(issue_uses_rs2),
        .issue_rd(issue_rd), .issue_writes_rd(issue_writes_rd),
        .jump_taken(jump_taken), .mem_stall(mem_stall),
        .flush_req(flush_req), .resume(resume),
        .pc_en(s_pc_en), .stall_issue(s_stall_issue), .squash_issue(s_squash_issue),
        .pipe_freeze(s_pipe_freeze), .halted(s_halted),
        .stall_cycles(s_stall_cycles), .squash_count(s_squash_count)
    );

    // ---------------- reference model ----------------
    typedef enum int { M_RUN, M_DRAIN, M_HALTED } mstate_e;
    typedef struct { int unsigned rd; int unsigned age; } flight_t;  // age 0=D .. 3=W

    flight_t     fl[$];
    mstate_e     ms;
    int unsigned m_stall, m_sq;
    logic        x_pc, x_st, x_sq, x_fz, x_hz;

    function automatic logic busy(input int unsigned r);
        foreach (fl[i]) begin
            if (fl[i].age <= 2 && fl[i].rd == r) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int unsigned clip(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        fl.delete();
        ms      = M_RUN;
        m_stall = 0;
        m_sq    = 0;
    endtask

    task automatic model_eval();
        x_hz = issue_valid && ms == M_RUN &&
               ((issue_uses_rs1 && issue_rs1 != 0 && busy(issue_rs1)) ||
                (issue_uses_rs2 && issue_rs2 != 0 && busy(issue_rs2)));
        x_pc = 0; x_st = 0; x_sq = 0; x_fz = 0;
        if (mem_stall) begin
            x_fz = 1; x_st = 1;
        end else if (jump_taken) begin
            x_sq = 1; x_pc = 1;
        end else if (x_hz || ms != M_RUN || flush_req) begin
            x_st = 1;
        end else begin
            x_pc = 1;
        end
    endtask

    task automatic model_clock();
        mstate_e nxt;
        if (rst) begin
            model_reset();
            return;
        end
        if (x_hz && !mem_stall) m_stall++;
        if (x_sq) m_sq++;
        nxt = ms;
        if (ms == M_RUN && flush_req) nxt = M_DRAIN;
        else if (ms == M_DRAIN && fl.size() == 0) nxt = M_HALTED;
        else if (ms == M_HALTED && resume) nxt = M_RUN;
        if (!mem_stall) begin
            foreach (fl[i]) fl[i].age++;
            for (int i = int'(fl.size()) - 1; i >= 0; i--) begin
                if (fl[i].age > 3) fl.delete(i);
            end
            if (!x_st && !x_sq && ms == M_RUN && issue_valid && issue_writes_rd && issue_rd != 0)
                fl.push_back('{rd: issue_rd, age: 0});
        end
        ms = nxt;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare all outputs with the model, then clock once and advance the model.
    task automatic step();
        #1;
        model_eval();
        chk("pc_en", 32'(pc_en), 32'(x_pc));
        chk("stall_issue", 32'(stall_issue), 32'(x_st));
        chk("squash_issue", 32'(squash_issue), 32'(x_sq));
        chk("pipe_freeze", 32'(pipe_freeze), 32'(x_fz));
        chk("halted", 32'(halted), 32'(ms == M_HALTED));
        chk("stall_cycles", 32'(stall_cycles), clip(m_stall, 65535));
        chk("squash_count", 32'(squash_count), clip(m_sq, 65535));
        chk("sat_stall_issue", 32'(s_stall_issue), 32'(x_st));
        chk("sat_stall_cycles", 32'(s_stall_cycles), clip(m_stall, 15));
        chk("sat_squash_count", 32'(s_squash_count), clip(m_sq, 15));
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic drive(input logic v, input int unsigned rs1, input int unsigned rs2,
                         input logic u1, input logic u2, input int unsigned rd, input logic wr);
        issue_valid = v; issue_rs1 = REG_W'(rs1); issue_rs2 = REG_W'(rs2);
        issue_uses_rs1 = u1; issue_uses_rs2 = u2;
        issue_rd = REG_W'(rd); issue_writes_rd = wr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
        jump_taken = 0; mem_stall = 0; flush_req = 0; resume = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic v; int unsigned rs1; int unsigned rs2; logic u1; logic u2;
        int unsigned rd; logic wr; logic jmp; logic mem;
        logic pc; logic st; logic sq; logic fz; int unsigned stc; int unsigned sqc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, int unsigned rs1, int unsigned rs2, logic u1, logic u2,
                                int unsigned rd, logic wr, logic jmp, logic mem,
                                logic pc, logic st, logic sq, logic fz,
                                int unsigned stc, int unsigned sqc);
        return '{v, rs1, rs2, u1, u2, rd, wr, jmp, mem, pc, st, sq, fz, stc, sqc};
    endfunction

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;

        // reset state, RAW on r5, r0 immunity, jump vs hazard, memory freeze
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,0,0, 0,0));
        tbl.push_back(mk(1,0,0,0,0,5,1,0,0, 1,0,0,0, 0,0));
        tbl.push_back(mk(1,5,0,1,0,6,0,0,0, 0,1,0,0, 0,0));
        tbl.push_back(mk(1,5,0,1,0,6,0,0,0, 0,1,0,0, 1,0));
        tbl.push_back(mk(1,5,0,1,0,6,0,0,0, 0,1,0,0, 2,0));
        tbl.push_back(mk(1,5,0,1,0,6,0,0,0, 1,0,0,0, 3,0));
        tbl.push_back(mk(1,0,0,0,0,0,1,0,0, 1,0,0,0, 3,0));
        tbl.push_back(mk(1,0,0,1,1,0,0,0,0, 1,0,0,0, 3,0));
        tbl.push_back(mk(1,0,0,0,0,7,1,0,0, 1,0,0,0, 3,0));
        tbl.push_back(mk(1,0,7,0,1,9,1,1,0, 1,0,1,0, 3,0));
        tbl.push_back(mk(1,9,0,1,0,0,0,0,0, 1,0,0,0, 4,1));
        tbl.push_back(mk(1,0,0,0,0,3,1,0,0, 1,0,0,0, 4,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,0,0, 4,1));
        tbl.push_back(mk(1,3,0,1,0,0,0,0,1, 0,1,0,1, 4,1));
        tbl.push_back(mk(1,3,0,1,0,0,0,1,1, 0,1,0,1, 4,1));
        tbl.push_back(mk(1,3,0,1,0,0,0,0,1, 0,1,0,1, 4,1));
        tbl.push_back(mk(1,3,0,1,0,0,0,0,1, 0,1,0,1, 4,1));
        tbl.push_back(mk(1,3,0,1,0,0,0,0,0, 0,1,0,0, 4,1));
        tbl.push_back(mk(1,3,0,1,0,0,0,0,0, 0,1,0,0, 5,1));
        tbl.push_back(mk(1,3,0,1,0,0,0,0,0, 1,0,0,0, 6,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,0,0, 6,1));

        foreach (tbl[k]) begin
            drive(tbl[k].v, tbl[k].rs1, tbl[k].rs2, tbl[k].u1, tbl[k].u2, tbl[k].rd, tbl[k].wr);
            jump_taken = tbl[k].jmp;
            mem_stall  = tbl[k].mem;
            #1;
            chk($sformatf("vec%0d_pc_en", k), 32'(pc_en), 32'(tbl[k].pc));
            chk($sformatf("vec%0d_stall", k), 32'(stall_issue), 32'(tbl[k].st));
            chk($sformatf("vec%0d_squash", k), 32'(squash_issue), 32'(tbl[k].sq));
            chk($sformatf("vec%0d_freeze", k), 32'(pipe_freeze), 32'(tbl[k].fz));
            chk($sformatf("vec%0d_halted", k), 32'(halted), 32'd0);
            chk($sformatf("vec%0d_stall_cycles", k), 32'(stall_cycles), tbl[k].stc);
            chk($sformatf("vec%0d_squash_count", k), 32'(squash_count), tbl[k].sqc);
            step();
        end
        idle();

        // drain with three writers in flight, then halt and resume
        drive(1, 0, 0, 0, 0, 10, 1); step();
        drive(1, 0, 0, 0, 0, 11, 1); step();
        drive(1, 0, 0, 0, 0, 12, 1); step();
        idle();
        flush_req = 1;
        #1;
        chk("flush_stall", 32'(stall_issue), 32'd1);
        chk("flush_pc_en", 32'(pc_en), 32'd0);
        step();
        flush_req = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("drain%0d_halted", k), 32'(halted), 32'd0);
            chk($sformatf("drain%0d_pc_en", k), 32'(pc_en), 32'd0);
            step();
        end
        #1;
        chk("halted_after_drain", 32'(halted), 32'd1);
        step();
        flush_req = 1;
        step();
        flush_req = 0;
        resume = 1;
        #1;
        chk("resume_cycle_halted", 32'(halted), 32'd1);
        step();
        resume = 0;
        #1;
        chk("resume_pc_en", 32'(pc_en), 32'd1);
        chk("resume_halted", 32'(halted), 32'd0);
        step();

        // reset in the middle of a drain
        drive(1, 0, 0, 0, 0, 13, 1); step();
        drive(1, 0, 0, 0, 0, 14, 1); step();
        idle();
        flush_req = 1; step();
        flush_req = 0; step();
        rst = 1; step();
        rst = 0;
        #1;
        chk("rst_pc_en", 32'(pc_en), 32'd1);
        chk("rst_stall", 32'(stall_issue), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_stall_cycles", 32'(stall_cycles), 32'd0);
        chk("rst_squash_count", 32'(squash_count), 32'd0);
        step();

        // saturation: self-dependent r5 stream stalls 3 of every 4 cycles
        drive(1, 5, 0, 1, 0, 5, 1);
        repeat (80) step();
        #1;
        chk("sat_stall_ffff", 32'(s_stall_cycles), 32'hF);
        idle();
        jump_taken = 1;
        repeat (20) step();
        #1;
        chk("sat_squash_ffff", 32'(s_squash_count), 32'hF);
        idle();
        step();

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 2) != 0);
            jump_taken = ($urandom_range(0, 9) == 0);
            mem_stall  = ($urandom_range(0, 6) == 0);
            flush_req  = ($urandom_range(0, 49) == 0);
            resume     = ($urandom_range(0, 9) == 0);
            rst        = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 0;
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
